// File: rtl/divider_pkg.sv
// Shared constants for the fixed-point divider: default word/fraction widths,
// FSM state encoding and saturation limits for the default word width.
package divider_pkg;

  localparam int DIV_N = 16;
  localparam int DIV_Q = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_N-1:0] SAT_MAX_POS = {1'b0, {(DIV_N-1){1'b1}}};
  localparam logic [DIV_N-1:0] SAT_MIN_NEG = {1'b1, {(DIV_N-1){1'b0}}};

endpackage

// File: rtl/divider.sv
// Signed fixed-point Q(N-Q).Q divider: sign-magnitude restoring division,
// one quotient bit per clock, saturating result with overflow/div-zero flags.
module divider
  import divider_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int Q = DIV_Q
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] out,
  output logic         o_ovf,
  output logic         o_div_zero
);

  localparam int CNT_W = $clog2(N + Q + 1);
  localparam logic [N-1:0] MAX_POS = (N == DIV_N) ? SAT_MAX_POS : {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = (N == DIV_N) ? SAT_MIN_NEG : {1'b1, {(N-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       rem;
  logic [N+Q-1:0]   num_quo;  // numerator shifts out the top, quotient bits enter the bottom
  logic [N-1:0]     b_mag;
  logic             res_neg;
  logic             a_neg;
  logic             div_zero;

  logic [N-1:0] a_abs, b_abs;
  logic [N:0]   trial, diff;
  logic         fits;
  logic [N:0]   result;

  // Magnitudes as unsigned N-bit values; the most negative input maps to 2^(N-1).
  assign a_abs = i_A[N-1] ? (~i_A + N'(1)) : i_A;
  assign b_abs = i_B[N-1] ? (~i_B + N'(1)) : i_B;

  assign trial = {rem[N-1:0], num_quo[N+Q-1]};
  assign diff  = trial - {1'b0, b_mag};
  assign fits  = (trial >= {1'b0, b_mag});

  // Returns {ovf, value}; negating a zero magnitude yields +0.
  function automatic logic [N:0] saturate(input logic [N+Q-1:0] mag, input logic negative);
    if (!negative) begin
      if (mag > (N+Q)'(MAX_POS)) return {1'b1, MAX_POS};
      return {1'b0, mag[N-1:0]};
    end
    if (mag > (N+Q)'(MIN_NEG)) return {1'b1, MIN_NEG};
    return {1'b0, N'(0) - mag[N-1:0]};
  endfunction

  assign result = div_zero ? {1'b0, (a_neg ? MIN_NEG : MAX_POS)}
                           : saturate(num_quo, res_neg);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      num_quo    <= '0;
      b_mag      <= '0;
      res_neg    <= 1'b0;
      a_neg      <= 1'b0;
      div_zero   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      out        <= '0;
      o_ovf      <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      // Status outputs are registered from the state, trailing it by one cycle.
      o_busy <= (state == CALC);
      o_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (i_start) begin
            a_neg   <= i_A[N-1];
            res_neg <= i_A[N-1] ^ i_B[N-1];
            if (i_B == '0) begin
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              div_zero <= 1'b0;
              b_mag    <= b_abs;
              num_quo  <= {a_abs, {Q{1'b0}}};
              rem      <= '0;
              cnt      <= '0;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem     <= fits ? diff : trial;
          num_quo <= {num_quo[N+Q-2:0], fits};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(N + Q - 1)) state <= DONE;
        end
        DONE: begin
          out        <= result[N-1:0];
          o_ovf      <= result[N];
          o_div_zero <= div_zero;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the fixed-point divider (N=16, Q=8).
module tb_divider;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_A = '0;
  logic [15:0] i_B = '0;
  logic        o_busy, o_done, o_ovf, o_div_zero;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  divider #(.N(16), .Q(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_A(i_A), .i_B(i_B),
    .o_busy(o_busy), .o_done(o_done), .out(out), .o_ovf(o_ovf), .o_div_zero(o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        ovf;
    logic        dz;
    int          lat;
    int          busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after the edge that sampled i_start; returns at the negedge where o_done is seen.
  task automatic wait_done(input int poke, output int lat, output int busy, output bit timeout);
    lat = 0; busy = 0; timeout = 0;
    forever begin
      @(negedge i_clk);
      if (o_done) break;
      if (lat > 60) begin timeout = 1; break; end
      busy += int'(o_busy);
      if (lat == poke) begin
        i_start = 1'b1; i_A = 16'h7F00; i_B = 16'h0001;
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_clk);
      lat++;
    end
    i_start = 1'b0;
  endtask

  // Must be called at a negedge.
  task automatic run_vec(input vec_t v, input int poke, input string tag);
    int lat, busy;
    bit to;
    i_A = v.a; i_B = v.b; i_start = 1'b1;
    @(posedge i_clk);
    wait_done(poke, lat, busy, to);
    check({tag, " timeout"}, 32'(to), 32'd0);
    check({tag, " out"}, 32'(out), 32'(v.q));
    check({tag, " ovf"}, 32'(o_ovf), 32'(v.ovf));
    check({tag, " div_zero"}, 32'(o_div_zero), 32'(v.dz));
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " busy cycles"}, 32'(busy), 32'(v.busy));
    @(negedge i_clk);
    check({tag, " done pulse width"}, 32'(o_done), 32'd0);
    check({tag, " out held"}, 32'(out), 32'(v.q));
  endtask

  initial begin
    vec_t vecs[13];
    vec_t v;
    int dones;
    vecs[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25, 24};
    vecs[1]  = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25, 24};
    vecs[2]  = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25, 24};
    vecs[3]  = '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25, 24};
    vecs[4]  = '{16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 25, 24};
    vecs[5]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25, 24};
    vecs[6]  = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25, 24};
    vecs[7]  = '{16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1, 0};
    vecs[8]  = '{16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1, 0};
    vecs[9]  = '{16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 25, 24};
    vecs[10] = '{16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 25, 24};
    vecs[11] = '{16'hC000, 16'h0080, 16'h8000, 1'b0, 1'b0, 25, 24};
    vecs[12] = '{16'h0080, 16'h0200, 16'h0040, 1'b0, 1'b0, 25, 24};

    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset out", 32'(out), 32'd0);
    check("reset ovf", 32'(o_ovf), 32'd0);
    check("reset div_zero", 32'(o_div_zero), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Each vector starts in the cycle right after the previous o_done pulse.
    for (int i = 0; i < 13; i++) run_vec(vecs[i], -1, $sformatf("vec%0d", i));

    // A start pulse with different operands mid-calculation must be ignored.
    run_vec(vecs[0], 5, "ignored start");
    run_vec(vecs[2], -1, "after ignored");

    // Reset mid-calculation aborts with no o_done.
    i_A = 16'h0300; i_B = 16'h0200; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("abort busy", 32'(o_busy), 32'd0);
    check("abort done", 32'(o_done), 32'd0);
    check("abort out", 32'(out), 32'd0);
    check("abort ovf", 32'(o_ovf), 32'd0);
    check("abort div_zero", 32'(o_div_zero), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      dones += int'(o_done);
    end
    check("no done after abort", 32'(dones), 32'd0);

    v = '{16'h0400, 16'h0200, 16'h0200, 1'b0, 1'b0, 25, 24};
    run_vec(v, -1, "post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
